dense_seq_ctrl: RTL and testbench
=================================

Name: dense_seq_ctrl

Overview:
Sequential controller for one fully-connected layer. It walks the input vector and the weight matrix through a single signed multiply-accumulate, one output neuron at a time, and applies ReLU. It writes each activation to an output buffer. On the final layer it also tracks the argmax class index (0=A, 1=B, ...). It sits between the layer's input/weight RAMs and the next layer's input buffer, and is started by the top-level network sequencer.

Parameters:
IBW, 202, input element MSB index (element width IBW+1, signed)
KBW, 32, weight element MSB index (width KBW+1, signed)
OBW, IBW+KBW, output/accumulator MSB index (width OBW+1, signed)
IN_COLS, 128, input vector length = weight rows
OUT_COLS, 512, output length = weight columns
FLAG_OUT, 0, 1 = final layer: argmax enabled
IAW, 7, input address width (covers IN_COLS-1)
WAW, 16, weight address width (covers IN_COLS*OUT_COLS-1)
OAW, 9, output address width (covers OUT_COLS-1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin layer; sampled in IDLE only
in_addr  out  IAW  input RAM read address
in_data  in  IBW+1  input RAM data, valid 1 cycle after address
w_addr  out  WAW  weight RAM read address, row-major: k*OUT_COLS+j
w_data  in  KBW+1  weight RAM data, valid 1 cycle after address
out_we  out  1  output buffer write strobe
out_addr  out  OAW  output index j
out_data  out  OBW+1  ReLU'd activation
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  1-cycle pulse at end of layer
class_idx  out  6  argmax index, valid when FLAG_OUT=1
class_valid  out  1  high from done until the next accepted start (FLAG_OUT=1 only; else 0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: addresses, out_we, out_data, busy, done, class_idx, class_valid. Accumulator, max and counters are cleared. A reset mid-layer aborts immediately and issues no further writes.
- FSM states: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE: when start=1, set j=0, k=0, acc=0, max=0, class_idx=0, clear class_valid, go to MAC. start is ignored in all other states.
- MAC: on each cycle, drive in_addr=k and w_addr=k*OUT_COLS+j, then increment k. The product of the data returned for the previous cycle's address is added to acc. The first MAC cycle of a neuron adds nothing. When k=IN_COLS-1 has been issued, go to DRAIN.
- DRAIN: add the last product. Go to WRITE.
- WRITE: out_we=1 for exactly this cycle, out_addr=j, out_data = (acc<0) ? 0 : acc.
  - If FLAG_OUT=1 and relu > max (strict), update max and set class_idx=j[5:0]. Ties keep the lower j; if all outputs are 0, class_idx=0.
  - Then clear acc and k. If j=OUT_COLS-1 go to DONE, else increment j and go to MAC.
- DONE: done=1 for one cycle, busy drops with it. class_valid is set (FLAG_OUT=1). Go to IDLE.
- Arithmetic:
  - Product = signed in_data × signed w_data, sign-extended to OBW+1 bits.
  - Accumulate in OBW+1 bits with two's-complement wrap; no saturation.
  - ReLU compares the signed acc against 0.
- Latency: each neuron takes IN_COLS+2 cycles (IN_COLS MAC, 1 DRAIN, 1 WRITE). A layer takes OUT_COLS*(IN_COLS+2) cycles plus 1 DONE cycle, counted from the first MAC cycle.
- Outputs hold their value outside WRITE, but out_data is qualified by out_we only.
- Back-to-back: start asserted in the cycle after DONE is accepted, and that new start clears class_valid.

Test Plan:
1. IN_COLS=4, OUT_COLS=3, inputs {1,2,3,4}, weight column0={1,1,1,1}, col1={-1,-1,-1,-1}, col2={2,0,0,1}: expect writes (0,10), (1,0), (2,6). out_we pulses 6 cycles apart; done arrives 19 cycles after the first MAC cycle.
2. FLAG_OUT=1, same data: class_idx=0, class_valid=1 after done. Change col2 to {4,0,0,4} (sum 20): class_idx=2. Tie test with col0=col2=10: class_idx=0.
3. All weights negative: every out_data=0; with FLAG_OUT=1, class_idx=0.
4. Signed extremes: in_data=most-negative IBW+1 value, w_data=-1, IN_COLS=1: out_data=+2^IBW, no truncation. Repeat with w_data=+1: out_data=0.
5. Pulse start during busy: no effect, and the address sequence is unchanged. Reset asserted mid-WRITE: out_we drops asynchronously, all outputs are 0, and the FSM is in IDLE with no done.
6. Check the address pattern: for j=1, the w_addr sequence is 1, 4, 7, 10 (OUT_COLS=3) and in_addr is 0..3, each on consecutive cycles.

Source files
------------

// File: rtl/dense_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dense_seq_ctrl
// Purpose  : Sequential controller for one fully-connected layer. Streams the
//            input vector and one weight column at a time through a single
//            signed multiply-accumulate, applies ReLU, writes each activation
//            to the output buffer and, on the final layer, tracks the argmax
//            class index.
// Ports    : clk, rst_n      - clock / asynchronous active-low reset
//            start           - begin a layer (sampled in IDLE only)
//            in_addr/in_data - input RAM port (data valid 1 cycle after addr)
//            w_addr/w_data   - weight RAM port, row-major k*OUT_COLS+j
//            out_we/out_addr/out_data - output buffer write port
//            busy, done      - layer status; done is a 1-cycle pulse
//            class_idx/class_valid - argmax result (FLAG_OUT=1 only)
// Revision : 1.0 - initial release
// ============================================================================
module dense_seq_ctrl #(
    parameter int IBW      = 202,
    parameter int KBW      = 32,
    parameter int OBW      = IBW + KBW,
    parameter int IN_COLS  = 128,
    parameter int OUT_COLS = 512,
    parameter int FLAG_OUT = 0,
    parameter int IAW      = 7,
    parameter int WAW      = 16,
    parameter int OAW      = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [IAW-1:0] in_addr,
    input  logic [IBW:0]   in_data,
    output logic [WAW-1:0] w_addr,
    input  logic [KBW:0]   w_data,
    output logic           out_we,
    output logic [OAW-1:0] out_addr,
    output logic [OBW:0]   out_data,
    output logic           busy,
    output logic           done,
    output logic [5:0]     class_idx,
    output logic           class_valid
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [IAW-1:0] K_LAST    = IAW'(IN_COLS - 1);
    localparam logic [IAW-1:0] K_ONE     = IAW'(1);
    localparam logic [OAW-1:0] J_LAST    = OAW'(OUT_COLS - 1);
    localparam logic [OAW-1:0] J_ONE     = OAW'(1);
    localparam logic [WAW-1:0] W_STRIDE  = WAW'(OUT_COLS);
    localparam logic [WAW-1:0] W_ONE     = WAW'(1);
    localparam logic           ARGMAX_EN = (FLAG_OUT != 0);

    state_t         state_q, state_d;
    logic [IAW-1:0] k_q, k_d;
    logic [OAW-1:0] j_q, j_d;
    logic [OBW:0]   acc_q, acc_d;
    logic [OBW:0]   max_q, max_d;
    logic [WAW-1:0] w_addr_q, w_addr_d;
    logic           out_we_q, out_we_d;
    logic [OAW-1:0] out_addr_q, out_addr_d;
    logic [OBW:0]   out_data_q, out_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [5:0]     class_idx_q, class_idx_d;
    logic           class_valid_q, class_valid_d;

    // Operands are sign-extended to the accumulator width so an unsigned
    // multiply yields the two's-complement product modulo 2^(OBW+1).
    logic [OBW:0] in_ext;
    logic [OBW:0] w_ext;
    logic [OBW:0] prod;
    logic [5:0]   j_cls;

    assign in_ext = {{KBW{in_data[IBW]}}, in_data};
    assign w_ext  = {{IBW{w_data[KBW]}}, w_data};
    assign prod   = in_ext * w_ext;

    // Class index is the low six bits of the neuron index.
    generate
        if (OAW >= 6) begin : g_cls_wide
            assign j_cls = j_q[5:0];
        end else begin : g_cls_narrow
            assign j_cls = {{(6 - OAW){1'b0}}, j_q};
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        j_d           = j_q;
        acc_d         = acc_q;
        max_d         = max_q;
        w_addr_d      = w_addr_q;
        out_we_d      = 1'b0;
        out_addr_d    = out_addr_q;
        out_data_d    = out_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        class_idx_d   = class_idx_q;
        class_valid_d = class_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_MAC;
                    k_d           = '0;
                    j_d           = '0;
                    acc_d         = '0;
                    max_d         = '0;
                    w_addr_d      = '0;
                    class_idx_d   = '0;
                    class_valid_d = 1'b0;
                    busy_d        = 1'b1;
                end
            end
            ST_MAC: begin
                // k_q is the address presented this cycle; data for the
                // previous address arrives now, except on the first cycle.
                if (k_q != '0) begin
                    acc_d = acc_q + prod;
                end
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d      = k_q + K_ONE;
                    w_addr_d = w_addr_q + W_STRIDE;
                end
            end
            ST_DRAIN: begin
                // Last product lands here; the ReLU result is registered so
                // it is on out_data during the WRITE cycle.
                acc_d      = acc_q + prod;
                out_we_d   = 1'b1;
                out_addr_d = j_q;
                out_data_d = acc_d[OBW] ? '0 : acc_d;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                // Strict compare keeps the lowest index on ties.
                if (ARGMAX_EN && (out_data_q > max_q)) begin
                    max_d       = out_data_q;
                    class_idx_d = j_cls;
                end
                acc_d = '0;
                k_d   = '0;
                if (j_q == J_LAST) begin
                    state_d       = ST_DONE;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    class_valid_d = ARGMAX_EN;
                end else begin
                    j_d      = j_q + J_ONE;
                    w_addr_d = WAW'(j_q) + W_ONE;
                    state_d  = ST_MAC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            j_q           <= '0;
            acc_q         <= '0;
            max_q         <= '0;
            w_addr_q      <= '0;
            out_we_q      <= 1'b0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            class_idx_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            j_q           <= j_d;
            acc_q         <= acc_d;
            max_q         <= max_d;
            w_addr_q      <= w_addr_d;
            out_we_q      <= out_we_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            class_idx_q   <= class_idx_d;
            class_valid_q <= class_valid_d;
        end
    end

    assign in_addr     = k_q;
    assign w_addr      = w_addr_q;
    assign out_we      = out_we_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign class_idx   = class_idx_q;
    assign class_valid = class_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dense_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_seq_ctrl
// Purpose  : Self-checking bench for dense_seq_ctrl. A 4x3 final-layer
//            instance is run on directed and random layers; a 1x2 hidden-layer
//            instance covers the single-input case and the disabled argmax.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_seq_ctrl;

    localparam int IBW = 7;
    localparam int KBW = 7;
    localparam int OBW = IBW + KBW;
    localparam int NI  = 4;
    localparam int NO  = 3;
    localparam int IAW = 2;
    localparam int WAW = 4;
    localparam int OAW = 2;
    localparam int NI0 = 1;
    localparam int NO0 = 2;
    localparam int LAYER_CYC  = NO * (NI + 2) + 1;
    localparam int LAYER_CYC0 = NO0 * (NI0 + 2) + 1;

    typedef logic signed [IBW:0] in_t;
    typedef logic signed [KBW:0] wt_t;
    typedef struct {
        int     addr;
        longint data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic start0 = 1'b0;

    logic [IAW-1:0] in_addr;
    logic [IBW:0]   in_data;
    logic [WAW-1:0] w_addr;
    logic [KBW:0]   w_data;
    logic           out_we;
    logic [OAW-1:0] out_addr;
    logic [OBW:0]   out_data;
    logic           busy, done;
    logic [5:0]     class_idx;
    logic           class_valid;

    logic [0:0]     in_addr0;
    logic [IBW:0]   in_data0;
    logic [0:0]     w_addr0;
    logic [KBW:0]   w_data0;
    logic           out_we0;
    logic [0:0]     out_addr0;
    logic [OBW:0]   out_data0;
    logic           busy0, done0;
    logic [5:0]     class_idx0;
    logic           class_valid0;

    in_t mem_in  [4];
    wt_t mem_w   [16];
    in_t mem0_in [2];
    wt_t mem0_w  [2];

    wr_t exp_wr[$];
    int  exp_cls[$];
    wr_t exp_wr0[$];

    int  checks = 0;
    int  errors = 0;
    bit  exp_cv = 1'b0;

    always #5 clk = ~clk;

    dense_seq_ctrl #(
        .IBW(IBW), .KBW(KBW), .OBW(OBW), .IN_COLS(NI), .OUT_COLS(NO),
        .FLAG_OUT(1), .IAW(IAW), .WAW(WAW), .OAW(OAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_addr(in_addr), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done),
        .class_idx(class_idx), .class_valid(class_valid)
    );

    dense_seq_ctrl #(
        .IBW(IBW), .KBW(KBW), .OBW(OBW), .IN_COLS(NI0), .OUT_COLS(NO0),
        .FLAG_OUT(0), .IAW(1), .WAW(1), .OAW(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .in_addr(in_addr0), .in_data(in_data0),
        .w_addr(w_addr0), .w_data(w_data0),
        .out_we(out_we0), .out_addr(out_addr0), .out_data(out_data0),
        .busy(busy0), .done(done0),
        .class_idx(class_idx0), .class_valid(class_valid0)
    );

    // Synchronous-read RAMs: data appears one cycle after the address.
    always @(posedge clk) begin
        in_data  <= mem_in[in_addr];
        w_data   <= mem_w[w_addr];
        in_data0 <= mem0_in[in_addr0];
        w_data0  <= mem0_w[w_addr0];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: dot product wrapped to OBW+1 bits, then ReLU.
    function automatic longint relu_wrap(input longint s);
        logic [OBW:0] w;
        w = s[OBW:0];
        if (w[OBW]) return 0;
        return longint'(w);
    endfunction

    function automatic longint neuron(input int j);
        longint s = 0;
        for (int k = 0; k < NI; k++) s += longint'(mem_in[k]) * longint'(mem_w[k*NO + j]);
        return relu_wrap(s);
    endfunction

    function automatic wt_t rnd_val();
        case ($urandom_range(0, 5))
            0: return wt_t'(-128);
            1: return wt_t'(127);
            2: return wt_t'(-1);
            default: return wt_t'($urandom);
        endcase
    endfunction

    task automatic set_in(input int a, input int b, input int c, input int d);
        mem_in[0] = in_t'(a); mem_in[1] = in_t'(b);
        mem_in[2] = in_t'(c); mem_in[3] = in_t'(d);
    endtask

    task automatic set_col(input int j, input int a, input int b, input int c, input int d);
        mem_w[0*NO+j] = wt_t'(a); mem_w[1*NO+j] = wt_t'(b);
        mem_w[2*NO+j] = wt_t'(c); mem_w[3*NO+j] = wt_t'(d);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_addr"},     in_addr, 0);
        chk({tag, "_w_addr"},      w_addr, 0);
        chk({tag, "_out_we"},      out_we, 0);
        chk({tag, "_out_addr"},    out_addr, 0);
        chk({tag, "_out_data"},    out_data, 0);
        chk({tag, "_busy"},        busy, 0);
        chk({tag, "_done"},        done, 0);
        chk({tag, "_class_idx"},   class_idx, 0);
        chk({tag, "_class_valid"}, class_valid, 0);
    endtask

    task automatic do_abort();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        exp_wr.delete();
        exp_cls.delete();
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_not_busy", busy, 0);
        end
        rst_n  = 1'b1;
        exp_cv = 1'b0;
    endtask

    // Called at a falling edge while the main instance is idle.
    task automatic run_layer(input bit noisy, input bit abort);
        longint r;
        longint best = 0;
        int     idx  = 0;
        int     n;
        bit     fin  = 1'b0;
        bit     aborted = 1'b0;
        chk("class_valid_idle", class_valid, longint'(exp_cv));
        for (int j = 0; j < NO; j++) begin
            r = neuron(j);
            exp_wr.push_back('{addr: j, data: r});
            if (r > best) begin
                best = r;
                idx  = j;
            end
        end
        exp_cls.push_back(idx);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!fin) begin
            int c, jj, p;
            c  = n - 1;
            jj = c / (NI + 2);
            p  = c % (NI + 2);
            if (n == 1) begin
                chk("busy_first_mac", busy, 1);
                chk("class_valid_cleared", class_valid, 0);
            end
            if (jj < NO && p < NI) begin
                chk("in_addr_seq", in_addr, p);
                chk("w_addr_seq", w_addr, p*NO + jj);
            end
            if (jj < NO) chk("we_timing", out_we, (p == NI + 1) ? 1 : 0);
            if (done) begin
                chk("done_latency", n, LAYER_CYC);
                fin = 1'b1;
            end else if (abort && out_we && jj == 1) begin
                do_abort();
                aborted = 1'b1;
                fin = 1'b1;
            end else if (n >= LAYER_CYC + 4) begin
                chk("done_timeout", n, LAYER_CYC);
                fin = 1'b1;
            end else begin
                start = noisy && (n < LAYER_CYC - 2) && ($urandom_range(0, 3) == 0);
                @(negedge clk);
                n++;
            end
        end
        start  = 1'b0;
        exp_cv = !aborted && done;
        @(negedge clk);
    endtask

    task automatic run_layer0();
        int n;
        for (int j = 0; j < NO0; j++)
            exp_wr0.push_back('{addr: j, data: relu_wrap(longint'(mem0_in[0]) * longint'(mem0_w[j]))});
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 1;
        while (!done0 && n < LAYER_CYC0 + 4) begin
            @(negedge clk);
            n++;
        end
        chk("done0_latency", n, LAYER_CYC0);
        @(negedge clk);
    endtask

    // Monitors: compare every write / done against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_we) begin
                if (exp_wr.size() == 0) chk("unexpected_write", out_addr, -1);
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", out_addr, e.addr);
                    chk("wr_data", out_data, e.data);
                end
            end
            if (done) begin
                if (exp_cls.size() == 0) chk("unexpected_done", done, 0);
                else begin
                    int c;
                    c = exp_cls.pop_front();
                    chk("class_idx", class_idx, c);
                    chk("class_valid_at_done", class_valid, 1);
                    chk("busy_low_at_done", busy, 0);
                end
            end
            if (out_we0) begin
                if (exp_wr0.size() == 0) chk("unexpected_write0", out_addr0, -1);
                else begin
                    wr_t e;
                    e = exp_wr0.pop_front();
                    chk("wr0_addr", out_addr0, e.addr);
                    chk("wr0_data", out_data0, e.data);
                end
            end
            if (done0) begin
                chk("class_idx0_disabled", class_idx0, 0);
                chk("class_valid0_disabled", class_valid0, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) mem_in[i] = '0;
        for (int i = 0; i < 16; i++) mem_w[i] = '0;
        for (int i = 0; i < 2; i++) begin
            mem0_in[i] = '0;
            mem0_w[i]  = '0;
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        chk("reset_dut0", {out_we0, busy0, done0, class_valid0, out_data0}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference layer: expected writes 10, 0, 6 and class 0.
        set_in(1, 2, 3, 4);
        set_col(0, 1, 1, 1, 1);
        set_col(1, -1, -1, -1, -1);
        set_col(2, 2, 0, 0, 1);
        run_layer(0, 0);
        // Column 2 sums to 20: class 2.
        set_col(2, 4, 0, 0, 4);
        run_layer(0, 0);
        // Tie at 10 between columns 0 and 2: lower index wins.
        set_col(2, 1, 1, 1, 1);
        run_layer(0, 0);
        // All-negative weights: every activation 0, class 0.
        set_col(0, -1, -2, -3, -4);
        set_col(1, -128, -1, -5, -7);
        set_col(2, -9, -9, -9, -9);
        run_layer(0, 0);
        // Signed extremes including wrap of -128*-128 products.
        set_in(-128, -128, -128, -128);
        set_col(0, -1, -1, -1, -1);
        set_col(1, 1, 1, 1, 1);
        set_col(2, -128, -128, -128, -128);
        run_layer(0, 0);

        // Random layers, with stray start pulses while busy.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < NI; i++) mem_in[i] = in_t'(rnd_val());
            for (int i = 0; i < NI*NO; i++) mem_w[i] = rnd_val();
            run_layer(t % 2 == 0, 0);
        end

        // Reset during the second WRITE, then a clean layer afterwards.
        run_layer(0, 1);
        for (int i = 0; i < NI*NO; i++) mem_w[i] = rnd_val();
        run_layer(1, 0);

        // Single-input hidden layer: -2^IBW * -1 = +2^IBW, and * +1 -> 0.
        mem0_in[0] = in_t'(-128);
        mem0_w[0]  = wt_t'(-1);
        mem0_w[1]  = wt_t'(1);
        run_layer0();
        for (int t = 0; t < 4; t++) begin
            mem0_in[0] = in_t'(rnd_val());
            mem0_w[0]  = rnd_val();
            mem0_w[1]  = rnd_val();
            run_layer0();
        end

        repeat (2) @(negedge clk);
        chk("queues_drained", exp_wr.size() + exp_cls.size() + exp_wr0.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
